ysyx_25040129_ifu: RTL and testbench
====================================

Name: ysyx_25040129_ifu

Overview:
Instruction fetch stage. It sits directly upstream of the decode stage and feeds that stage's inst/pc/valid inputs. It owns the architectural fetch PC and issues single-beat reads to the instruction memory over an AXI4-Lite-style read channel (AR/R). It presents one fetched instruction at a time to decode with a valid/ready handshake, and accepts PC redirects from downstream (branch, jal/jalr, ecall, mret, fence.i).

Parameters:
RESET_PC, 32'h3000_0000, PC of the first fetch after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
ifu_araddr  out  32  read address; equals pc_reg while in REQ.
ifu_arvalid  out  1  read request valid.
ifu_arready  in  1  memory accepts the request.
ifu_rdata  in  32  returned instruction word.
ifu_rresp  in  2  response; nonzero means access fault.
ifu_rvalid  in  1  read data valid.
ifu_rready  out  1  IFU accepts read data.
inst_out_ifu  out  32  instruction to decode.
pc_out_ifu  out  32  PC of inst_out_ifu.
fault_out_ifu  out  1  fetch access fault for the presented instruction.
is_req_valid_to_idu  out  1  instruction presented.
is_req_ready_from_idu  in  1  decode accepts.
redirect_valid  in  1  downstream requests a PC change.
redirect_pc  in  32  new fetch PC; bits [1:0] are forced to 0.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. Reset state is IDLE.
- Reset values: pc_reg=RESET_PC, inst_reg=0, fault_reg=0, kill=0, tgt_reg=0.
- Reset values of outputs: arvalid=0, rready=0, is_req_valid_to_idu=0, pc_out_ifu=RESET_PC, inst_out_ifu=0, fault_out_ifu=0.
- Reset mid-transaction: everything returns to its reset value asynchronously. Any outstanding memory response after reset is the memory's concern; the IFU re-fetches RESET_PC.
- IDLE -> REQ unconditionally on the next cycle.
- REQ:
  - arvalid=1 and araddr=pc_reg.
  - Once asserted, arvalid and araddr stay stable until arready, even if a redirect arrives.
  - A redirect in REQ sets kill=1 and tgt_reg=redirect_pc.
  - arvalid&&arready -> WAIT.
- WAIT:
  - rready=1.
  - On rvalid, if kill or redirect_valid is set this cycle, the data is discarded. pc_reg takes redirect_pc if redirect_valid is set, otherwise tgt_reg. kill clears and the next state is REQ.
  - On rvalid with no kill and no redirect, inst_reg=rdata and fault_reg=(rresp!=0), then -> HOLD.
  - A redirect in WAIT without rvalid sets kill=1 and tgt_reg=redirect_pc.
  - When several redirects occur before the response, the latest one wins.
- HOLD:
  - is_req_valid_to_idu=1. inst, pc and fault are stable until accepted.
  - If redirect_valid is set, it takes priority over ready: the held instruction is wrong-path and is dropped (valid drops the next cycle), pc_reg=redirect_pc, -> REQ.
  - Otherwise, on ready: pc_reg=pc_reg+4 (wraps mod 2^32), -> REQ.
- Outputs: valid, arvalid and rready are pure decodes of state. pc_out_ifu=pc_reg.
- A redirect in IDLE updates pc_reg directly.
- Throughput: at least 3 cycles per instruction (REQ, WAIT, HOLD), one outstanding read at most. A fault does not stall the IFU; decode/EXU handles the trap.

Decomposition:
- Shared define file: state encodings, RESET_PC default, and the RESP_OKAY constant. These use the ysyx_25040129_ macro prefix so the decode and memory-bridge stages can share them.
- No sub-module. The FSM plus pc/inst registers are a single module.

Test Plan:
- Reset release with arready=1 and rvalid one cycle after AR, rdata=32'h00000413, idu ready=1: first araddr=32'h3000_0000; valid is asserted 3 cycles after leaving IDLE with pc_out=32'h3000_0000; the next araddr is 32'h3000_0004.
- Decode holds ready=0 for 5 cycles in HOLD: valid, inst and pc stay constant; no new arvalid. ready=1 then advances the PC by 4.
- Redirect to 32'h8000_0102 while in WAIT, then response 32'hDEADBEEF arrives: DEADBEEF is never presented; the next araddr is 32'h8000_0100.
- Redirect to 32'h3000_0040 in REQ with arready held low 3 cycles: araddr stays at the old PC until accepted; the response is discarded; the next fetch is 32'h3000_0040.
- Redirect and ready in the same HOLD cycle: the instruction is dropped and the next fetch uses the redirect PC, not pc+4.
- rresp=2'b10 with rdata=0: presented with fault_out_ifu=1; after acceptance the PC advances by 4. Asserting rst in WAIT returns arvalid=0 immediately and the refetch is at RESET_PC.

Source files
------------

// File: rtl/ysyx_25040129_ifu_pkg.sv
// Shared definitions for the ysyx_25040129 pipeline: IFU state encoding,
// default reset PC, AXI response code and a PC alignment helper.
package ysyx_25040129_ifu_pkg;

    typedef enum logic [1:0] {
        YSYX_25040129_IDLE = 2'd0,
        YSYX_25040129_REQ  = 2'd1,
        YSYX_25040129_WAIT = 2'd2,
        YSYX_25040129_HOLD = 2'd3
    } ysyx_25040129_ifu_state_e;

    localparam logic [31:0] YSYX_25040129_RESET_PC  = 32'h3000_0000;
    localparam logic [1:0]  YSYX_25040129_RESP_OKAY = 2'b00;

    // Instructions are word aligned; the low two bits of any target are dropped.
    function automatic logic [31:0] ysyx_25040129_align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25040129_ifu.sv
// Instruction fetch stage: owns the fetch PC, issues one AR/R read at a time
// and presents the fetched word to decode with a valid/ready handshake.
// Redirects that arrive while a read is in flight mark it as killed so the
// response is dropped and the fetch restarts at the latest target.
module ysyx_25040129_ifu
    import ysyx_25040129_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = YSYX_25040129_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ifu_araddr,
    output logic        ifu_arvalid,
    input  logic        ifu_arready,
    input  logic [31:0] ifu_rdata,
    input  logic [1:0]  ifu_rresp,
    input  logic        ifu_rvalid,
    output logic        ifu_rready,
    output logic [31:0] inst_out_ifu,
    output logic [31:0] pc_out_ifu,
    output logic        fault_out_ifu,
    output logic        is_req_valid_to_idu,
    input  logic        is_req_ready_from_idu,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    ysyx_25040129_ifu_state_e state_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        fault_r;
    logic        kill_r;
    logic [31:0] tgt_r;
    logic [31:0] redirect_aligned_s;

    assign redirect_aligned_s = ysyx_25040129_align_pc(redirect_pc);

    // Fetch FSM together with the PC, held instruction and kill bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= YSYX_25040129_IDLE;
            pc_r    <= RESET_PC;
            inst_r  <= 32'd0;
            fault_r <= 1'b0;
            kill_r  <= 1'b0;
            tgt_r   <= 32'd0;
        end else begin
            case (state_r)
                YSYX_25040129_IDLE: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_aligned_s;
                    end
                    state_r <= YSYX_25040129_REQ;
                end
                YSYX_25040129_REQ: begin
                    // Address must stay stable until accepted, so a redirect
                    // here is only remembered and applied after the response.
                    if (redirect_valid) begin
                        kill_r <= 1'b1;
                        tgt_r  <= redirect_aligned_s;
                    end
                    if (ifu_arready) begin
                        state_r <= YSYX_25040129_WAIT;
                    end
                end
                YSYX_25040129_WAIT: begin
                    if (ifu_rvalid) begin
                        if (kill_r || redirect_valid) begin
                            pc_r    <= redirect_valid ? redirect_aligned_s : tgt_r;
                            kill_r  <= 1'b0;
                            state_r <= YSYX_25040129_REQ;
                        end else begin
                            inst_r  <= ifu_rdata;
                            fault_r <= (ifu_rresp != YSYX_25040129_RESP_OKAY);
                            state_r <= YSYX_25040129_HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill_r <= 1'b1;
                        tgt_r  <= redirect_aligned_s;
                    end
                end
                YSYX_25040129_HOLD: begin
                    // A redirect means the held instruction is wrong-path.
                    if (redirect_valid) begin
                        pc_r    <= redirect_aligned_s;
                        state_r <= YSYX_25040129_REQ;
                    end else if (is_req_ready_from_idu) begin
                        pc_r    <= pc_r + 32'd4;
                        state_r <= YSYX_25040129_REQ;
                    end
                end
                default: begin
                    state_r <= YSYX_25040129_IDLE;
                end
            endcase
        end
    end

    assign ifu_arvalid         = (state_r == YSYX_25040129_REQ);
    assign ifu_rready          = (state_r == YSYX_25040129_WAIT);
    assign is_req_valid_to_idu = (state_r == YSYX_25040129_HOLD);
    assign ifu_araddr          = pc_r;
    assign pc_out_ifu          = pc_r;
    assign inst_out_ifu        = inst_r;
    assign fault_out_ifu       = fault_r;

endmodule

// File: tb/tb_ysyx_25040129_ifu.sv
// Directed bench for the fetch stage: a table of sequential fetches followed
// by hand-written sequences for stalls, redirects and reset mid-transaction.
module tb_ysyx_25040129_ifu;

    logic        clk;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] inst_out_ifu;
    logic [31:0] pc_out_ifu;
    logic        fault_out_ifu;
    logic        is_req_valid_to_idu;
    logic        is_req_ready_from_idu;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [4];

    ysyx_25040129_ifu dut (
        .clk                   (clk),
        .rst                   (rst),
        .ifu_araddr            (ifu_araddr),
        .ifu_arvalid           (ifu_arvalid),
        .ifu_arready           (ifu_arready),
        .ifu_rdata             (ifu_rdata),
        .ifu_rresp             (ifu_rresp),
        .ifu_rvalid            (ifu_rvalid),
        .ifu_rready            (ifu_rready),
        .inst_out_ifu          (inst_out_ifu),
        .pc_out_ifu            (pc_out_ifu),
        .fault_out_ifu         (fault_out_ifu),
        .is_req_valid_to_idu   (is_req_valid_to_idu),
        .is_req_ready_from_idu (is_req_ready_from_idu),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for a read request, check its address, then accept it.
    task automatic do_ar(input logic [31:0] exp_addr, input string nm);
        int n = 0;
        while (!ifu_arvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_arvalid"}, {31'd0, ifu_arvalid}, 32'd1);
        chk({nm, "_araddr"}, ifu_araddr, exp_addr);
        ifu_arready = 1'b1;
        @(negedge clk);
        ifu_arready = 1'b0;
    endtask

    // Return one read beat; the IFU must be waiting for it.
    task automatic do_r(input logic [31:0] data, input logic [1:0] resp, input string nm);
        chk({nm, "_rready"}, {31'd0, ifu_rready}, 32'd1);
        chk({nm, "_novalid_in_wait"}, {31'd0, is_req_valid_to_idu}, 32'd0);
        ifu_rvalid = 1'b1;
        ifu_rdata  = data;
        ifu_rresp  = resp;
        @(negedge clk);
        ifu_rvalid = 1'b0;
        ifu_rdata  = 32'd0;
        ifu_rresp  = 2'b00;
    endtask

    // Check the presented instruction, then accept it.
    task automatic accept(input logic [31:0] e_inst, input logic [31:0] e_pc,
                          input logic e_fault, input string nm);
        chk({nm, "_valid"}, {31'd0, is_req_valid_to_idu}, 32'd1);
        chk({nm, "_inst"}, inst_out_ifu, e_inst);
        chk({nm, "_pc"}, pc_out_ifu, e_pc);
        chk({nm, "_fault"}, {31'd0, fault_out_ifu}, {31'd0, e_fault});
        is_req_ready_from_idu = 1'b1;
        @(negedge clk);
        is_req_ready_from_idu = 1'b0;
    endtask

    initial begin
        vecs[0] = '{rdata: 32'h0000_0413, rresp: 2'b00, exp_pc: 32'h3000_0000, exp_fault: 1'b0};
        vecs[1] = '{rdata: 32'h0010_0093, rresp: 2'b00, exp_pc: 32'h3000_0004, exp_fault: 1'b0};
        vecs[2] = '{rdata: 32'h0000_0000, rresp: 2'b10, exp_pc: 32'h3000_0008, exp_fault: 1'b1};
        vecs[3] = '{rdata: 32'hFFFF_FFFF, rresp: 2'b11, exp_pc: 32'h3000_000C, exp_fault: 1'b1};

        rst = 1'b1;
        ifu_arready = 1'b0;
        ifu_rdata = 32'd0;
        ifu_rresp = 2'b00;
        ifu_rvalid = 1'b0;
        is_req_ready_from_idu = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_arvalid", {31'd0, ifu_arvalid}, 32'd0);
        chk("rst_rready", {31'd0, ifu_rready}, 32'd0);
        chk("rst_valid", {31'd0, is_req_valid_to_idu}, 32'd0);
        chk("rst_pc", pc_out_ifu, 32'h3000_0000);
        chk("rst_inst", inst_out_ifu, 32'd0);
        chk("rst_fault", {31'd0, fault_out_ifu}, 32'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("first_req_arvalid", {31'd0, ifu_arvalid}, 32'd1);

        // Sequential fetches, decode always ready.
        for (int i = 0; i < 4; i++) begin
            do_ar(vecs[i].exp_pc, $sformatf("seq%0d", i));
            do_r(vecs[i].rdata, vecs[i].rresp, $sformatf("seq%0d", i));
            accept(vecs[i].rdata, vecs[i].exp_pc, vecs[i].exp_fault, $sformatf("seq%0d", i));
        end

        // Decode stalls five cycles in HOLD.
        do_ar(32'h3000_0010, "stall");
        do_r(32'h1234_5678, 2'b00, "stall");
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {31'd0, is_req_valid_to_idu}, 32'd1);
            chk("stall_inst", inst_out_ifu, 32'h1234_5678);
            chk("stall_pc", pc_out_ifu, 32'h3000_0010);
            chk("stall_no_arvalid", {31'd0, ifu_arvalid}, 32'd0);
            @(negedge clk);
        end
        accept(32'h1234_5678, 32'h3000_0010, 1'b0, "stall_acc");

        // Redirect while waiting for the response; that response is dropped.
        do_ar(32'h3000_0014, "rdw");
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
        do_r(32'hDEAD_BEEF, 2'b00, "rdw");
        chk("rdw_dropped_valid", {31'd0, is_req_valid_to_idu}, 32'd0);
        chk("rdw_next_arvalid", {31'd0, ifu_arvalid}, 32'd1);
        chk("rdw_next_araddr", ifu_araddr, 32'h8000_0100);

        // Redirect while the request is stalled by the memory.
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000_0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rdq_arvalid_held", {31'd0, ifu_arvalid}, 32'd1);
            chk("rdq_araddr_held", ifu_araddr, 32'h8000_0100);
            @(negedge clk);
        end
        do_ar(32'h8000_0100, "rdq");
        do_r(32'hCAFE_F00D, 2'b00, "rdq");
        chk("rdq_dropped_valid", {31'd0, is_req_valid_to_idu}, 32'd0);
        chk("rdq_next_araddr", ifu_araddr, 32'h3000_0040);

        // Redirect and ready together in HOLD: redirect wins.
        do_ar(32'h3000_0040, "rdh");
        do_r(32'h0000_0013, 2'b00, "rdh");
        chk("rdh_valid", {31'd0, is_req_valid_to_idu}, 32'd1);
        chk("rdh_pc", pc_out_ifu, 32'h3000_0040);
        is_req_ready_from_idu = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000_0200;
        @(negedge clk);
        is_req_ready_from_idu = 1'b0;
        redirect_valid = 1'b0;
        chk("rdh_valid_drop", {31'd0, is_req_valid_to_idu}, 32'd0);
        chk("rdh_next_araddr", ifu_araddr, 32'h3000_0200);

        // Two redirects before the response: the later one wins.
        do_ar(32'h3000_0200, "rd2");
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000_0100;
        @(negedge clk);
        redirect_pc = 32'h3000_0204;
        @(negedge clk);
        redirect_valid = 1'b0;
        do_r(32'h1111_1111, 2'b00, "rd2");
        chk("rd2_dropped_valid", {31'd0, is_req_valid_to_idu}, 32'd0);
        chk("rd2_next_araddr", ifu_araddr, 32'h3000_0204);

        // Reset asserted while waiting for a response.
        do_ar(32'h3000_0204, "rstw");
        chk("rstw_in_wait", {31'd0, ifu_rready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_arvalid", {31'd0, ifu_arvalid}, 32'd0);
        chk("rstw_rready", {31'd0, ifu_rready}, 32'd0);
        chk("rstw_pc", pc_out_ifu, 32'h3000_0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_ar(32'h3000_0000, "rstw_refetch");
        do_r(32'h0000_0413, 2'b00, "rstw_refetch");
        accept(32'h0000_0413, 32'h3000_0000, 1'b0, "rstw_refetch");
        chk("rstw_after_araddr", ifu_araddr, 32'h3000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
